// File: rtl/temperature_incrementor_lut.sv
// Wash temperature selector: per-programme fixed temperature lists, stepped by a
// debounced-level "temperature +" button, with the list entry looked up combinationally.
module temperature_incrementor_lut (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] wash_mode,
  input  logic       increment,
  output logic [6:0] selected_temperature
);

  logic [2:0] mode_q;
  logic [2:0] idx_q;
  logic       inc_q;

  logic       mode_change_s;
  logic       step_s;
  logic [2:0] len_s;
  logic [2:0] idx_next_s;

  function automatic logic [2:0] list_len(input logic [2:0] mode);
    case (mode)
      3'd0:    list_len = 3'd5;
      3'd1:    list_len = 3'd4;
      3'd2:    list_len = 3'd3;
      3'd3:    list_len = 3'd3;
      3'd4:    list_len = 3'd3;
      3'd5:    list_len = 3'd2;
      3'd6:    list_len = 3'd3;
      default: list_len = 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] default_idx(input logic [2:0] mode);
    case (mode)
      3'd0:    default_idx = 3'd2;
      3'd1:    default_idx = 3'd2;
      3'd2:    default_idx = 3'd1;
      3'd3:    default_idx = 3'd2;
      3'd4:    default_idx = 3'd1;
      3'd5:    default_idx = 3'd0;
      3'd6:    default_idx = 3'd1;
      default: default_idx = 3'd0;
    endcase
  endfunction

  // Case key is {mode, idx}, written in octal so each digit is one field.
  function automatic logic [6:0] list_entry(input logic [2:0] mode, input logic [2:0] idx);
    case ({mode, idx})
      6'o00:   list_entry = 7'd20;
      6'o01:   list_entry = 7'd30;
      6'o02:   list_entry = 7'd40;
      6'o03:   list_entry = 7'd60;
      6'o04:   list_entry = 7'd90;
      6'o10:   list_entry = 7'd20;
      6'o11:   list_entry = 7'd30;
      6'o12:   list_entry = 7'd40;
      6'o13:   list_entry = 7'd60;
      6'o20:   list_entry = 7'd20;
      6'o21:   list_entry = 7'd30;
      6'o22:   list_entry = 7'd40;
      6'o30:   list_entry = 7'd0;
      6'o31:   list_entry = 7'd20;
      6'o32:   list_entry = 7'd30;
      6'o40:   list_entry = 7'd20;
      6'o41:   list_entry = 7'd30;
      6'o42:   list_entry = 7'd40;
      6'o50:   list_entry = 7'd40;
      6'o51:   list_entry = 7'd60;
      6'o60:   list_entry = 7'd40;
      6'o61:   list_entry = 7'd60;
      6'o62:   list_entry = 7'd90;
      default: list_entry = 7'd0;
    endcase
  endfunction

  // Output lookup; an out-of-range position falls back to the programme default.
  always_comb begin
    len_s = list_len(mode_q);
    if (idx_q < len_s) begin
      selected_temperature = list_entry(mode_q, idx_q);
    end else begin
      selected_temperature = list_entry(mode_q, default_idx(mode_q));
    end
  end

  // Next-state decode: mode change has priority over a button rising edge.
  always_comb begin
    mode_change_s = (wash_mode != mode_q);
    step_s        = increment & ~inc_q;
    if ((idx_q + 3'd1) >= len_s) begin
      idx_next_s = 3'd0;
    end else begin
      idx_next_s = idx_q + 3'd1;
    end
  end

  // State registers; inc_q resets high so a button held through reset does not step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 3'd0;
      idx_q  <= 3'd2;
      inc_q  <= 1'b1;
    end else begin
      inc_q <= increment;
      if (mode_change_s) begin
        mode_q <= wash_mode;
        idx_q  <= default_idx(wash_mode);
      end else if (step_s) begin
        idx_q <= idx_next_s;
      end else begin
        idx_q <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_temperature_incrementor_lut.sv
// Self-checking bench for temperature_incrementor_lut: directed scenarios plus a
// randomized run checked against a list-based reference model.
module tb_temperature_incrementor_lut;

  logic       clk;
  logic       reset;
  logic [2:0] wash_mode;
  logic       increment;
  logic [6:0] selected_temperature;

  int checks = 0;
  int errors = 0;

  // Reference model: each programme is an ordinary list plus a default position.
  int lists[8][$];
  int defaults[8];
  int m_mode;
  int m_idx;
  int m_inc;

  temperature_incrementor_lut dut (
    .clk                  (clk),
    .reset                (reset),
    .wash_mode            (wash_mode),
    .increment            (increment),
    .selected_temperature (selected_temperature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_temp();
    return lists[m_mode][m_idx];
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_idx  = defaults[0];
    m_inc  = 1;
  endtask

  task automatic model_clock();
    if (reset) begin
      model_reset();
    end else begin
      if (int'(wash_mode) != m_mode) begin
        m_mode = int'(wash_mode);
        m_idx  = defaults[m_mode];
      end else if (increment && m_inc == 0) begin
        m_idx = (m_idx + 1) % lists[m_mode].size();
      end
      m_inc = int'(increment);
    end
  endtask

  // One clock: model follows the edge, then we return at the falling edge for sampling.
  task automatic do_cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic check_const(input string name, input int expected);
    checks++;
    if (int'(selected_temperature) !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, selected_temperature, expected, $time);
    end
  endtask

  task automatic pulse();
    increment = 1'b1;
    do_cycle();
    increment = 1'b0;
    do_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; wash_mode = 3'd0; increment = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (selected_temperature !== 7'd40) begin
      errors++;
      $display("FAIL reset_value: got %0d expected 40", selected_temperature);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      checks++;
      if (selected_temperature !== 7'd40) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %0d expected 40", i, selected_temperature);
      end
    end
  endtask

  task automatic test_cotton_cycle();
    int exp_seq[5] = '{60, 90, 20, 30, 40};
    wash_mode = 3'd0;
    for (int i = 0; i < 5; i++) begin
      pulse();
      checks++;
      if (int'(selected_temperature) !== exp_seq[i]) begin
        errors++;
        $display("FAIL cotton_step[%0d]: got %0d expected %0d", i, selected_temperature, exp_seq[i]);
      end
    end
  endtask

  task automatic test_mode_defaults();
    int exp_def[8] = '{40, 40, 30, 30, 30, 40, 60, 0};
    increment = 1'b0;
    for (int m = 0; m < 8; m++) begin
      wash_mode = 3'(m);
      do_cycle();
      do_cycle();
      checks++;
      if (int'(selected_temperature) !== exp_def[m]) begin
        errors++;
        $display("FAIL mode_default[%0d]: got %0d expected %0d", m, selected_temperature, exp_def[m]);
      end
    end
    // Single-entry programme: a step keeps it at cold.
    pulse();
    check_const("rinse_step", 0);
  endtask

  task automatic test_held_button();
    wash_mode = 3'd6; increment = 1'b0;
    do_cycle();
    do_cycle();
    check_const("intensive_default", 60);
    increment = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      checks++;
      if (selected_temperature !== 7'd90) begin
        errors++;
        $display("FAIL held_step[%0d]: got %0d expected 90", i, selected_temperature);
      end
    end
    increment = 1'b0;
    do_cycle();
    check_const("held_release", 90);
    pulse();
    check_const("held_wrap", 40);
  endtask

  task automatic test_simultaneous();
    wash_mode = 3'd1; increment = 1'b0;
    do_cycle();
    do_cycle();
    check_const("synth_default", 40);
    pulse();
    check_const("synth_idx3", 60);
    wash_mode = 3'd2; increment = 1'b1;
    do_cycle();
    check_const("simul_mode_wins", 30);
    do_cycle();
    check_const("simul_no_late_step", 30);
    increment = 1'b0;
    do_cycle();
  endtask

  task automatic test_async_reset();
    wash_mode = 3'd5; increment = 1'b0;
    do_cycle();
    check_const("eco_default", 40);
    pulse();
    check_const("eco_60", 60);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_const("async_reset_immediate", 40);
    do_cycle();
    reset = 1'b0;
    do_cycle();
    check_const("eco_after_reset", 40);
    // Button held across reset release must not step.
    wash_mode = 3'd0; increment = 1'b1; reset = 1'b1;
    model_reset();
    do_cycle();
    reset = 1'b0;
    do_cycle();
    check_const("held_through_reset", 40);
    do_cycle();
    check_const("held_through_reset_2", 40);
    increment = 1'b0;
    do_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (int'(selected_temperature) !== model_temp()) begin
          errors++;
          $display("FAIL rand_reset[%0d]: got %0d expected %0d", i, selected_temperature, model_temp());
        end
        do_cycle();
        reset = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) wash_mode = 3'($urandom_range(0, 7));
      increment = 1'($urandom_range(0, 1));
      do_cycle();
      checks++;
      if (int'(selected_temperature) !== model_temp()) begin
        errors++;
        $display("FAIL rand[%0d]: got %0d expected %0d (mode %0d)", i, selected_temperature, model_temp(), m_mode);
      end
    end
  endtask

  initial begin
    lists[0] = '{20, 30, 40, 60, 90};
    lists[1] = '{20, 30, 40, 60};
    lists[2] = '{20, 30, 40};
    lists[3] = '{0, 20, 30};
    lists[4] = '{20, 30, 40};
    lists[5] = '{40, 60};
    lists[6] = '{40, 60, 90};
    lists[7] = '{0};
    defaults = '{2, 2, 1, 2, 1, 0, 1, 0};

    test_reset();
    test_cotton_cycle();
    test_mode_defaults();
    test_held_button();
    test_simultaneous();
    test_async_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temperature_incrementor_lut.md
TEMPERATURE_INCREMENTOR_LUT -- requirements
Module: temperature_incrementor_lut

Interface
REQ-001 Parameters: none; all table contents are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wash_mode  input  3  wash programme select, values 0..7.
REQ-005 increment  input  1  user "temperature +" button, level signal, synchronous to clk.
REQ-006 selected_temperature  output  7  selected wash temperature in degrees C, unsigned; value 0 means cold.

Function
REQ-007 Each mode SHALL have the following fixed ascending temperature list, with the default shown as [default]:
- 0 Cotton: 20, 30, [40], 60, 90.
- 1 Synthetics: 20, 30, [40], 60.
- 2 Delicates: 20, [30], 40.
- 3 Wool: 0, 20, [30].
- 4 Quick: 20, [30], 40.
- 5 Eco: [40], 60.
- 6 Intensive: 40, [60], 90.
- 7 Rinse/Spin: [0].
REQ-008 State SHALL be held in these registers:
- mode_q: 3 bits, the registered mode.
- idx_q: 3 bits, the position in the list.
- inc_q: 1 bit, the previous increment value.
REQ-009 selected_temperature SHALL be a purely combinational lookup of the list entry at position idx_q for mode mode_q, with no extra register stage.
REQ-010 If idx_q is at or beyond the list length for mode_q, the output SHALL be the default temperature of mode_q.
REQ-011 Mode change: when wash_mode differs from mode_q at a clock edge, mode_q SHALL load wash_mode and idx_q SHALL load the default index of the new mode.
- The output therefore shows the new mode's default one cycle after the change.
REQ-012 Increment: a rising edge of increment (increment=1 and inc_q=0) with no mode change SHALL advance idx_q by one.
- inc_q SHALL load increment on every clock edge.
REQ-013 Wrap-around: an increment applied at the last list entry SHALL set idx_q to 0, i.e. the lowest temperature.
REQ-014 For mode 7, which has a single entry, an increment SHALL leave the output at 0.
REQ-015 Holding increment high SHALL produce exactly one step; another step requires increment to go low and then high again.
REQ-016 When a mode change and an increment rising edge occur at the same edge, the mode change SHALL win and the increment SHALL be discarded.
- inc_q still updates at that edge.
REQ-017 With no mode change and no increment rising edge, all state SHALL hold.

Reset
REQ-018 While reset=1 the registers SHALL be forced immediately, independent of clk:
- mode_q = 0.
- idx_q = 2, the Cotton default.
- inc_q = 1.
REQ-019 During reset selected_temperature SHALL read 40.
REQ-020 Because inc_q resets to 1, an increment held high across reset release SHALL not step.
REQ-021 On the first clock edge after reset release, a wash_mode other than 0 SHALL load that mode's default per REQ-011.
REQ-022 Asserting reset in the middle of operation SHALL abandon the current selection and apply REQ-018.

Verification
REQ-023 Reset check: reset=1 with wash_mode=0 -> output 40; release reset with wash_mode=0 and increment=0 for 3 cycles -> output stays 40.
REQ-024 Cotton cycle: wash_mode=0, then five separate 1-cycle increment pulses -> outputs 60, 90, 20, 30, 40, confirming wrap-around.
REQ-025 Mode defaults: step wash_mode through 0..7, holding each value 2 cycles -> outputs 40, 40, 30, 30, 30, 40, 60, 0.
REQ-026 Held button: wash_mode=6 at default 60, increment held high for 5 cycles -> output becomes 90 and stays 90; release, then pulse again -> 40.
REQ-027 Simultaneous events: at Synthetics idx=3 (60), change wash_mode to 2 and raise increment at the same edge -> output 30, no step.
REQ-028 Asynchronous reset: wash_mode=5 showing 60, assert reset between clock edges -> output 40 before the next edge; release -> next edge output 40 (Eco default).
